// File: rtl/wb_data_port_arbiter.sv
// Two-master / one-slave pipelined Wishbone arbiter for the data memory path.
// Master 0 is the core data adapter, master 1 the loader/DMA. Round-robin
// between the masters, with a per-grant burst limit and a cap on requests
// that have been accepted but not yet acknowledged.
// Optional build macro WB_ARB_TIMEOUT_EN adds a response watchdog and timeout_o.
module wb_data_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_BURST       = 16,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_wb_cyc_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_we_i,
    input  logic [31:0] m0_wb_adr_i,
    input  logic [31:0] m0_wb_dat_i,
    input  logic [3:0]  m0_wb_sel_i,
    output logic        m0_wb_stall_o,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_err_o,
    output logic [31:0] m0_wb_dat_o,
    input  logic        m1_wb_cyc_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_we_i,
    input  logic [31:0] m1_wb_adr_i,
    input  logic [31:0] m1_wb_dat_i,
    input  logic [3:0]  m1_wb_sel_i,
    output logic        m1_wb_stall_o,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_err_o,
    output logic [31:0] m1_wb_dat_o,
    output logic        s_wb_cyc_o,
    output logic        s_wb_stb_o,
    output logic        s_wb_we_o,
    output logic [31:0] s_wb_adr_o,
    output logic [31:0] s_wb_dat_o,
    output logic [3:0]  s_wb_sel_o,
    input  logic        s_wb_stall_i,
    input  logic        s_wb_ack_i,
    input  logic        s_wb_err_i,
    input  logic [31:0] s_wb_dat_i,
`ifdef WB_ARB_TIMEOUT_EN
    output logic        timeout_o,
`endif
    output logic [1:0]  grant_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CW-1:0] OUT_MAX   = CW'(MAX_OUTSTANDING);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        r_state, w_nxt_state;
    logic          r_last;
    logic [CW-1:0] r_out;
    logic [BW-1:0] r_burst;

    logic w_act, w_own1, w_cyc, w_stb, w_oth_cyc;
    logic w_yield, w_hold, w_pend, w_accept;
    logic w_ack, w_err, w_resp, w_to, w_release;

    // Owner-side request view; the mux select is the registered state only,
    // so nothing here depends on s_wb_stall_i.
    assign w_act     = (r_state != IDLE);
    assign w_own1    = (r_state == GNT1);
    assign w_cyc     = w_own1 ? m1_wb_cyc_i : m0_wb_cyc_i;
    assign w_stb     = w_own1 ? m1_wb_stb_i : m0_wb_stb_i;
    assign w_oth_cyc = w_own1 ? m0_wb_cyc_i : m1_wb_cyc_i;

    // Yield only matters once the burst budget is spent and someone is waiting.
    assign w_yield  = (MAX_BURST != 0) && (r_burst >= BURST_MAX) && w_oth_cyc;
    assign w_hold   = (r_out == OUT_MAX) || w_yield;
    assign w_pend   = (r_out != '0);

    assign s_wb_cyc_o = w_act & w_cyc;
    assign s_wb_stb_o = w_act & w_cyc & w_stb & ~w_hold;
    assign s_wb_we_o  = w_act & (w_own1 ? m1_wb_we_i : m0_wb_we_i);
    assign s_wb_adr_o = !w_act ? '0 : (w_own1 ? m1_wb_adr_i : m0_wb_adr_i);
    assign s_wb_dat_o = !w_act ? '0 : (w_own1 ? m1_wb_dat_i : m0_wb_dat_i);
    assign s_wb_sel_o = !w_act ? '0 : (w_own1 ? m1_wb_sel_i : m0_wb_sel_i);

    assign w_accept = s_wb_stb_o & ~s_wb_stall_i;
    // Responses with nothing in flight (spurious, or after an abort) are dropped.
    assign w_ack    = w_act & s_wb_ack_i & w_pend;
    assign w_err    = w_act & s_wb_err_i & w_pend;
    assign w_resp   = w_ack | w_err;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_to_cnt;

    // Watchdog: counts response-free cycles while requests are in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_to_cnt <= '0;
        else if (!w_pend || w_resp || w_release) r_to_cnt <= '0;
        else                                 r_to_cnt <= r_to_cnt + TW'(1);
    end

    assign w_to      = w_act & w_pend & ~w_resp & (r_to_cnt == TO_LAST);
    assign timeout_o = w_to;
`else
    // No watchdog in this build: a hung slave keeps the grant indefinitely.
    assign w_to = (TIMEOUT_CYCLES < 0);
`endif

    // Abort (cyc dropped), burst yield once drained, or watchdog expiry.
    assign w_release = w_act & (~w_cyc | (w_yield & ~w_pend) | w_to);

    assign m0_wb_stall_o = (r_state != GNT0) | s_wb_stall_i | w_hold;
    assign m1_wb_stall_o = (r_state != GNT1) | s_wb_stall_i | w_hold;
    assign m0_wb_ack_o   = (r_state == GNT0) & w_ack;
    assign m1_wb_ack_o   = w_own1 & w_ack;
    assign m0_wb_err_o   = (r_state == GNT0) & (w_err | w_to);
    assign m1_wb_err_o   = w_own1 & (w_err | w_to);
    assign m0_wb_dat_o   = (r_state == GNT0) ? s_wb_dat_i : '0;
    assign m1_wb_dat_o   = w_own1 ? s_wb_dat_i : '0;
    assign grant_o       = {w_own1, r_state == GNT0};

    // Next-state: round-robin tie break in IDLE, direct hand-over on release.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            IDLE: begin
                if (m0_wb_cyc_i && m1_wb_cyc_i) w_nxt_state = r_last ? GNT0 : GNT1;
                else if (m0_wb_cyc_i)           w_nxt_state = GNT0;
                else if (m1_wb_cyc_i)           w_nxt_state = GNT1;
            end
            GNT0, GNT1: begin
                if (w_release)
                    w_nxt_state = !w_oth_cyc ? IDLE : (w_own1 ? GNT0 : GNT1);
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // State register and the master that held the last grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            if (w_release) r_last <= w_own1;
        end
    end

    // In-flight request count; an abort forgets anything still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_out <= '0;
        else if (!w_act || w_release)  r_out <= '0;
        else if (w_accept && !w_resp)  r_out <= r_out + CW'(1);
        else if (!w_accept && w_resp)  r_out <= r_out - CW'(1);
    end

    // Accepts during the current grant, saturating at the burst limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_burst <= '0;
        else if (!w_act || w_release)              r_burst <= '0;
        else if (w_accept && (r_burst < BURST_MAX)) r_burst <= r_burst + BW'(1);
    end

endmodule

// File: tb/tb_wb_data_port_arbiter.sv
// Bench for wb_data_port_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_wb_data_port_arbiter;

    localparam int MO  = 4;
    localparam int MB  = 2;
    localparam int TO  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mcyc[2], mstb[2], mwe[2];
    logic [31:0] madr[2], mdin[2];
    logic [3:0]  msel[2];
    logic        mstall[2], mack[2], merr[2];
    logic [31:0] mdout[2];
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dout;
    logic [3:0]  s_sel;
    logic        s_stall, s_ack, s_err;
    logic [31:0] s_din;
    logic [1:0]  grant;
`ifdef WB_ARB_TIMEOUT_EN
    logic        tmo;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    wb_data_port_arbiter #(.MAX_OUTSTANDING(MO), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_wb_cyc_i(mcyc[0]), .m0_wb_stb_i(mstb[0]), .m0_wb_we_i(mwe[0]),
        .m0_wb_adr_i(madr[0]), .m0_wb_dat_i(mdin[0]), .m0_wb_sel_i(msel[0]),
        .m0_wb_stall_o(mstall[0]), .m0_wb_ack_o(mack[0]), .m0_wb_err_o(merr[0]),
        .m0_wb_dat_o(mdout[0]),
        .m1_wb_cyc_i(mcyc[1]), .m1_wb_stb_i(mstb[1]), .m1_wb_we_i(mwe[1]),
        .m1_wb_adr_i(madr[1]), .m1_wb_dat_i(mdin[1]), .m1_wb_sel_i(msel[1]),
        .m1_wb_stall_o(mstall[1]), .m1_wb_ack_o(mack[1]), .m1_wb_err_o(merr[1]),
        .m1_wb_dat_o(mdout[1]),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dout), .s_wb_sel_o(s_sel),
        .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
        .s_wb_dat_i(s_din),
`ifdef WB_ARB_TIMEOUT_EN
        .timeout_o(tmo),
`endif
        .grant_o(grant)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // owner: -1 none, 0/1 master index. Counters are plain integers.
    int m_own, m_out, m_burst, m_last, m_to;
    int n_own, n_out, n_burst, n_last, n_to;
    bit e_stall[2], e_ack[2], e_err[2], e_scyc, e_sstb, e_swe, e_tmo;
    logic [31:0] e_dat[2], e_sadr, e_sdat;
    logic [3:0]  e_ssel;
    logic [1:0]  e_grant;

    function automatic void model_eval();
        int x, y;
        bit yield, hold, resp, accept, fire, rel;
        for (int i = 0; i < 2; i++) begin
            e_stall[i] = 1'b1; e_ack[i] = 1'b0; e_err[i] = 1'b0; e_dat[i] = '0;
        end
        e_scyc = 0; e_sstb = 0; e_swe = 0; e_sadr = '0; e_sdat = '0; e_ssel = '0;
        e_grant = 2'b00; e_tmo = 0;
        n_own = m_own; n_out = m_out; n_burst = m_burst; n_last = m_last; n_to = m_to;
        if (!rst_n) begin
            n_own = -1; n_out = 0; n_burst = 0; n_last = 1; n_to = 0;
            return;
        end
        if (m_own < 0) begin
            if (mcyc[0] && mcyc[1]) n_own = 1 - m_last;
            else if (mcyc[0])       n_own = 0;
            else if (mcyc[1])       n_own = 1;
            return;
        end
        x = m_own; y = 1 - m_own;
        yield  = (MB != 0) && (m_burst >= MB) && mcyc[y];
        hold   = (m_out == MO) || yield;
        e_grant = (x == 0) ? 2'b01 : 2'b10;
        e_scyc = mcyc[x];
        e_sstb = mcyc[x] && mstb[x] && !hold;
        e_swe  = mwe[x]; e_sadr = madr[x]; e_sdat = mdin[x]; e_ssel = msel[x];
        e_stall[x] = s_stall || hold;
        e_dat[x]   = s_din;
        e_ack[x]   = s_ack && (m_out > 0);
        e_err[x]   = s_err && (m_out > 0);
        resp   = (s_ack || s_err) && (m_out > 0);
        accept = e_sstb && !s_stall;
        fire   = 0;
`ifdef WB_ARB_TIMEOUT_EN
        fire   = (m_out > 0) && !resp && (m_to == TO - 1);
        e_err[x] = e_err[x] || fire;
        e_tmo  = fire;
`endif
        rel = !mcyc[x] || (yield && m_out == 0) || fire;
        if (rel) begin
            n_own = mcyc[y] ? y : -1;
            n_out = 0; n_burst = 0; n_last = x; n_to = 0;
        end else begin
            n_out   = m_out + int'(accept) - int'(resp);
            n_burst = m_burst + int'(accept);
            n_to    = (resp || m_out == 0) ? 0 : m_to + 1;
        end
    endfunction

    // Advance one clock: commit model state, then step past the edge.
    task automatic tick();
        @(posedge clk);
        m_own = n_own; m_out = n_out; m_burst = n_burst; m_last = n_last; m_to = n_to;
        #1;
    endtask

    // Let freshly driven inputs settle and evaluate the model for this cycle.
    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            mcyc[i] = 0; mstb[i] = 0; mwe[i] = 0; madr[i] = '0; mdin[i] = '0; msel[i] = '0;
        end
        s_stall = 0; s_ack = 0; s_err = 0; s_din = '0;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        rst_n = 0;
        settle();
        tick(); settle();
        tick();
        rst_n = 1;
        settle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick();
        mcyc[0] = 1; mstb[0] = 1; madr[0] = 32'hdead_beef; s_ack = 1; s_din = 32'h5555_aaaa;
        rst_n = 0;
        settle();
        n_tests++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b want 00", grant); end
        n_tests++;
        if ({s_cyc, s_stb, s_we, s_adr, s_dout, s_sel} !== '0) begin
            n_fail++; $display("FAIL reset_slave_out got %h want 0", {s_cyc, s_stb, s_we, s_adr, s_dout, s_sel});
        end
        n_tests++;
        if ({mstall[0], mstall[1], mack[0], mack[1], merr[0], merr[1]} !== 6'b110000) begin
            n_fail++; $display("FAIL reset_master_ctl got %b want 110000",
                               {mstall[0], mstall[1], mack[0], mack[1], merr[0], merr[1]});
        end
        n_tests++;
        if ({mdout[0], mdout[1]} !== 64'h0) begin
            n_fail++; $display("FAIL reset_master_dat got %h want 0", {mdout[0], mdout[1]});
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        mcyc[0] = 1; mstb[0] = 1; mwe[0] = 0; madr[0] = 32'h8000_0010; msel[0] = 4'hf;
        settle();
        n_tests++;
        if ({grant, s_stb, mstall[0]} !== 4'b0001) begin
            n_fail++; $display("FAIL single_arb_latency got grant=%b stb=%b stall0=%b want 00/0/1", grant, s_stb, mstall[0]);
        end
        tick(); settle();
        n_tests++;
        if (grant !== 2'b01 || s_stb !== 1'b1 || s_adr !== 32'h8000_0010 || mstall[0] !== 1'b0 || mstall[1] !== 1'b1) begin
            n_fail++; $display("FAIL single_request got grant=%b stb=%b adr=%h st0=%b st1=%b want 01/1/80000010/0/1",
                               grant, s_stb, s_adr, mstall[0], mstall[1]);
        end
        tick(); mstb[0] = 0; settle();
        n_tests++;
        if (s_stb !== 1'b0 || mack[0] !== 1'b0 || mstall[1] !== 1'b1) begin
            n_fail++; $display("FAIL single_wait got stb=%b ack0=%b st1=%b want 0/0/1", s_stb, mack[0], mstall[1]);
        end
        tick(); s_ack = 1; s_din = 32'h1234_5678; settle();
        n_tests++;
        if (mack[0] !== 1'b1 || mdout[0] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL single_ack0 got ack=%b dat=%h want 1/12345678", mack[0], mdout[0]);
        end
        n_tests++;
        if (mack[1] !== 1'b0 || mdout[1] !== 32'h0 || mstall[1] !== 1'b1) begin
            n_fail++; $display("FAIL single_m1_quiet got ack=%b dat=%h st=%b want 0/0/1", mack[1], mdout[1], mstall[1]);
        end
        tick(); s_ack = 0; mcyc[0] = 0; settle();
        tick(); settle();
        n_tests++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL single_idle got %b want 00", grant); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] a0, a1, d1;
        a0 = $urandom; a1 = $urandom; d1 = $urandom;
        do_reset();
        mcyc[0] = 1; mstb[0] = 1; madr[0] = a0;
        mcyc[1] = 1; mstb[1] = 1; madr[1] = a1;
        settle();
        tick(); settle();
        n_tests++;
        if (grant !== 2'b01 || s_adr !== a0 || mstall[1] !== 1'b1) begin
            n_fail++; $display("FAIL tie_m0_first got grant=%b adr=%h st1=%b want 01/%h/1", grant, s_adr, mstall[1], a0);
        end
        tick(); mstb[0] = 0; s_ack = 1; settle();
        n_tests++;
        if (mack[0] !== 1'b1 || mack[1] !== 1'b0) begin
            n_fail++; $display("FAIL tie_ack0 got ack0=%b ack1=%b want 1/0", mack[0], mack[1]);
        end
        tick(); s_ack = 0; mcyc[0] = 0; settle();
        tick(); settle();
        n_tests++;
        if (grant !== 2'b10 || s_stb !== 1'b1 || s_adr !== a1 || mstall[1] !== 1'b0) begin
            n_fail++; $display("FAIL handover_m1 got grant=%b stb=%b adr=%h st1=%b want 10/1/%h/0", grant, s_stb, s_adr, mstall[1], a1);
        end
        tick(); mstb[1] = 0; s_ack = 1; s_din = d1; settle();
        n_tests++;
        if (mack[1] !== 1'b1 || mdout[1] !== d1 || mack[0] !== 1'b0) begin
            n_fail++; $display("FAIL handover_ack1 got ack1=%b dat=%h ack0=%b want 1/%h/0", mack[1], mdout[1], mack[0], d1);
        end
        tick(); s_ack = 0; mcyc[1] = 0; settle();
    endtask

    task automatic test_back_to_back();
        int q[$];
        int issued = 0, acks = 0, max_out = 0, stalls = 0, first_ack = -1, resume = -1;
        do_reset();
        mcyc[0] = 1;
        for (int c = 0; c < 40 && acks < 6; c++) begin
            if (c > 0) tick();
            s_ack = (q.size() > 0 && q[0] == c);
            if (s_ack) void'(q.pop_front());
            mstb[0] = (issued < 6);
            madr[0] = 32'h100 + 32'(issued * 4);
            settle();
            if (mack[0]) begin acks++; if (first_ack < 0) first_ack = c; end
            if (grant == 2'b01 && mstb[0] && mstall[0]) stalls++;
            if (mstb[0] && !mstall[0]) begin
                issued++;
                q.push_back(c + 4);
                if (stalls > 0 && resume < 0) resume = c;
            end
            if (issued - acks > max_out) max_out = issued - acks;
        end
        n_tests++;
        if (issued != 6 || acks != 6) begin
            n_fail++; $display("FAIL b2b_complete got issued=%0d acks=%0d want 6/6", issued, acks);
        end
        n_tests++;
        if (max_out != MO) begin n_fail++; $display("FAIL b2b_max_outstanding got %0d want %0d", max_out, MO); end
        n_tests++;
        if (stalls != 1) begin n_fail++; $display("FAIL b2b_stall_cycles got %0d want 1", stalls); end
        n_tests++;
        if (resume != first_ack + 1) begin
            n_fail++; $display("FAIL b2b_resume got cycle %0d want %0d", resume, first_ack + 1);
        end
        tick(); mstb[0] = 0; mcyc[0] = 0; s_ack = 0; settle();
    endtask

    task automatic test_burst_yield();
        int acc0 = 0, bad = 0;
        bit ack_next = 0, got1 = 0;
        do_reset();
        mcyc[0] = 1; mstb[0] = 1;
        mcyc[1] = 1; mstb[1] = 1; madr[1] = 32'hcafe_0001;
        for (int c = 0; c < 20 && !got1; c++) begin
            if (c > 0) tick();
            s_ack = ack_next; ack_next = 0;
            settle();
            if (grant == 2'b10) got1 = 1;
            else if (grant == 2'b01) begin
                if (!mstall[0]) begin acc0++; ack_next = 1; end
                else if (s_stb) bad++;
            end
        end
        n_tests++;
        if (!got1) begin n_fail++; $display("FAIL yield_grant_m1 got grant=%b want 10 within 20 cycles", grant); end
        n_tests++;
        if (acc0 != MB || bad != 0) begin
            n_fail++; $display("FAIL yield_burst_limit got accepts=%0d leaks=%0d want %0d/0", acc0, bad, MB);
        end
        n_tests++;
        if (mstall[1] !== 1'b0 || s_adr !== 32'hcafe_0001 || mstall[0] !== 1'b1) begin
            n_fail++; $display("FAIL yield_m1_active got st1=%b adr=%h st0=%b want 0/cafe0001/1", mstall[1], s_adr, mstall[0]);
        end
        tick(); s_ack = 0; idle_inputs(); settle();
    endtask

    task automatic test_spurious_and_reset();
        do_reset();
        s_ack = 1; settle();
        n_tests++;
        if (mack[0] !== 1'b0 || mack[1] !== 1'b0) begin
            n_fail++; $display("FAIL spurious_idle got ack0=%b ack1=%b want 0/0", mack[0], mack[1]);
        end
        tick(); mcyc[0] = 1; settle();
        tick(); settle();
        n_tests++;
        if (grant !== 2'b01 || mack[0] !== 1'b0) begin
            n_fail++; $display("FAIL spurious_granted got grant=%b ack0=%b want 01/0", grant, mack[0]);
        end
        tick(); s_ack = 0; mstb[0] = 1; settle();
        tick(); settle();
        tick(); mstb[0] = 0; rst_n = 0; s_ack = 1; settle();
        n_tests++;
        if ({grant, s_cyc, s_stb, mstall[0], mstall[1], mack[0], mack[1]} !== 8'b00001100) begin
            n_fail++; $display("FAIL midreset_outputs got %b want 00001100",
                               {grant, s_cyc, s_stb, mstall[0], mstall[1], mack[0], mack[1]});
        end
        tick(); rst_n = 1; settle();
        tick(); settle();
        n_tests++;
        if (grant !== 2'b01 || mack[0] !== 1'b0 || mack[1] !== 1'b0) begin
            n_fail++; $display("FAIL late_ack_dropped got grant=%b ack0=%b ack1=%b want 01/0/0", grant, mack[0], mack[1]);
        end
        tick(); idle_inputs(); settle();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k_err = -1, tmo_cnt = 0;
        do_reset();
        mcyc[0] = 1; mstb[0] = 1; settle();
        tick(); settle();
        tick(); mstb[0] = 0; settle();
        for (int k = 1; k < 30 && k_err < 0; k++) begin
            if (k > 1) begin tick(); settle(); end
            if (tmo) tmo_cnt++;
            if (merr[0]) k_err = k;
        end
        n_tests++;
        if (k_err != TO || tmo_cnt != 1) begin
            n_fail++; $display("FAIL timeout_err got cycle=%0d pulses=%0d want %0d/1", k_err, tmo_cnt, TO);
        end
        tick(); settle();
        n_tests++;
        if (grant !== 2'b00 || tmo !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle got grant=%b tmo=%b want 00/0", grant, tmo);
        end
        tick(); idle_inputs(); settle();
    endtask
`endif

    task automatic test_random();
        logic [142:0] act, exp;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 9) == 0) mcyc[i] = ~mcyc[i];
                mstb[i] = ($urandom_range(0, 3) != 0);
                mwe[i]  = 1'($urandom);
                madr[i] = $urandom; mdin[i] = $urandom; msel[i] = 4'($urandom);
            end
            s_stall = ($urandom_range(0, 3) == 0);
            s_ack   = ($urandom_range(0, 2) == 0);
            s_err   = ($urandom_range(0, 11) == 0);
            s_din   = $urandom;
            settle();
            act = {grant, s_cyc, s_stb, s_we, s_adr, s_dout, s_sel,
                   mstall[0], mstall[1], mack[0], mack[1], merr[0], merr[1], mdout[0], mdout[1]};
            exp = {e_grant, e_scyc, e_sstb, e_swe, e_sadr, e_sdat, e_ssel,
                   e_stall[0], e_stall[1], e_ack[0], e_ack[1], e_err[0], e_err[1], e_dat[0], e_dat[1]};
            n_tests++;
            if (act !== exp) begin
                n_fail++; $display("FAIL random_c%0d outputs got %h want %h", c, act, exp);
            end
`ifdef WB_ARB_TIMEOUT_EN
            n_tests++;
            if (tmo !== e_tmo) begin n_fail++; $display("FAIL random_c%0d timeout got %b want %b", c, tmo, e_tmo); end
`endif
        end
        tick(); idle_inputs(); settle();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        m_own = -1; m_out = 0; m_burst = 0; m_last = 1; m_to = 0;
        model_eval();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_burst_yield();
        test_spurious_and_reset();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
